// File: rtl/button_fsm_multi.sv
// N-channel push-button controller: 2-flop sync, debounce, per-channel
// momentary/toggle output and press/release/long-press event pulses.
//
//   state     | meaning
//   S_IDLE    | debounced level low, waiting for a press
//   S_PRESSED | press accepted, hold counter running toward long press
//   S_LONG    | long press reported, waiting for release
module button_fsm_multi #(
    parameter int N_CH              = 4,
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int LONG_PRESS_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] button,
    input  logic [N_CH-1:0] mode,
    output logic [N_CH-1:0] y,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LOAD  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_LONG    = 2'd2
    } state_t;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic          r_sync1;
        logic          r_sync2;
        logic          r_deb;
        logic [DW-1:0] r_deb_cnt;
        logic [HW-1:0] r_hold;
        logic          r_y;
        logic          r_press;
        logic          r_release;
        logic          r_long;
        state_t        r_state;
        state_t        w_state_nxt;
        logic          w_press;
        logic          w_release;
        logic          w_long;

        // Debounce down-counter reloads whenever the synced level agrees with deb.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_deb     <= 1'b0;
                r_deb_cnt <= DEB_LOAD;
            end else begin
                r_sync1 <= button[g];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_deb) begin
                    r_deb_cnt <= DEB_LOAD;
                end else if (r_deb_cnt == '0) begin
                    r_deb     <= r_sync2;
                    r_deb_cnt <= DEB_LOAD;
                end else begin
                    r_deb_cnt <= r_deb_cnt - DW'(1);
                end
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_press     = 1'b0;
            w_release   = 1'b0;
            w_long      = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_deb) begin
                        w_state_nxt = S_PRESSED;
                        w_press     = 1'b1;
                    end
                end
                S_PRESSED: begin
                    if (!r_deb) begin
                        w_state_nxt = S_IDLE;
                        w_release   = 1'b1;
                    end else if (r_hold == '0) begin
                        w_state_nxt = S_LONG;
                        w_long      = 1'b1;
                    end
                end
                S_LONG: begin
                    if (!r_deb) begin
                        w_state_nxt = S_IDLE;
                        w_release   = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= S_IDLE;
                r_hold    <= HOLD_LOAD;
                r_y       <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_press   <= w_press;
                r_release <= w_release;
                r_long    <= w_long;
                if (w_press) begin
                    r_hold <= HOLD_LOAD;
                end else if ((r_state == S_PRESSED) && (r_hold != '0)) begin
                    r_hold <= r_hold - HW'(1);
                end
                // Toggle mode only flips on a press; momentary tracks the state.
                if (!mode[g]) begin
                    r_y <= (w_state_nxt != S_IDLE);
                end else if (w_press) begin
                    r_y <= ~r_y;
                end
            end
        end

        assign y[g]             = r_y;
        assign press_pulse[g]   = r_press;
        assign release_pulse[g] = r_release;
        assign long_pulse[g]    = r_long;
    end

endmodule
